// File: rtl/llander_rom_pkg.sv
// Shared types and address-map constants for the Lunar Lander ROM download path.
// Region bases are derived from the three ROM sizes so the map stays consistent.
package llander_rom_pkg;

    localparam int PROG_BYTES = 8192;
    localparam int VEC_BYTES  = 2048;
    localparam int PROM_BYTES = 256;

    localparam logic [15:0] VEC_BASE  = 16'(PROG_BYTES);
    localparam logic [15:0] PROM_BASE = 16'(PROG_BYTES + VEC_BYTES);
    localparam logic [15:0] END_ADDR  = 16'(PROG_BYTES + VEC_BYTES + PROM_BYTES);

    // Byte counters carry one spare bit so an over-long region never aliases to "full".
    localparam int PROG_CNT_W = $clog2(PROG_BYTES + 1) + 1;
    localparam int VEC_CNT_W  = $clog2(VEC_BYTES + 1) + 1;
    localparam int PROM_CNT_W = $clog2(PROM_BYTES + 1) + 1;

    localparam logic [PROG_CNT_W-1:0] PROG_CNT_FULL = PROG_CNT_W'(PROG_BYTES);
    localparam logic [VEC_CNT_W-1:0]  VEC_CNT_FULL  = VEC_CNT_W'(VEC_BYTES);
    localparam logic [PROM_CNT_W-1:0] PROM_CNT_FULL = PROM_CNT_W'(PROM_BYTES);

    typedef enum logic [1:0] {
        REG_PROG,
        REG_VEC,
        REG_PROM,
        REG_NONE
    } region_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_READY,
        ST_ERR
    } state_e;

    function automatic region_e decode_region(input logic [15:0] addr);
        region_e r;
        if (addr < VEC_BASE)
            r = REG_PROG;
        else if (addr < PROM_BASE)
            r = REG_VEC;
        else if (addr < END_ADDR)
            r = REG_PROM;
        else
            r = REG_NONE;
        return r;
    endfunction

endpackage

// File: rtl/llander_vec_packer.sv
// Packs even/odd vector ROM bytes into 16-bit AVG words {odd, even}.
// Flags any byte that arrives out of pair order.
module llander_vec_packer
    import llander_rom_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_wr,
    input  logic [10:0] i_off,
    input  logic [7:0]  i_data,
    output logic        o_we,
    output logic [9:0]  o_addr,
    output logic [15:0] o_data,
    output logic        o_lo_valid,
    output logic        o_order_err
);

    logic        r_we;
    logic [9:0]  r_addr;
    logic [15:0] r_word;
    logic [7:0]  r_hold;
    logic [9:0]  r_idx;
    logic        r_lo_valid;
    logic        r_order_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_word      <= '0;
            r_hold      <= '0;
            r_idx       <= '0;
            r_lo_valid  <= 1'b0;
            r_order_err <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (i_clear) begin
                r_lo_valid  <= 1'b0;
                r_order_err <= 1'b0;
            end else if (i_wr) begin
                if (!i_off[0]) begin
                    // A second even byte before its partner loses the first one.
                    if (r_lo_valid)
                        r_order_err <= 1'b1;
                    r_hold     <= i_data;
                    r_idx      <= i_off[10:1];
                    r_lo_valid <= 1'b1;
                end else if (r_lo_valid && (r_idx == i_off[10:1])) begin
                    r_we       <= 1'b1;
                    r_word     <= {i_data, r_hold};
                    r_addr     <= i_off[10:1];
                    r_lo_valid <= 1'b0;
                end else begin
                    r_order_err <= 1'b1;
                end
            end
        end
    end

    assign o_we        = r_we;
    assign o_addr      = r_addr;
    assign o_data      = r_word;
    assign o_lo_valid  = r_lo_valid;
    assign o_order_err = r_order_err;

endmodule

// File: rtl/llander_rom_loader.sv
// HPS download receiver: routes stream bytes to program ROM, vector ROM and state PROM,
// then validates byte counts, pairing and range before releasing rom_ready.
module llander_rom_loader
    import llander_rom_pkg::*;
(
    input  logic        clk_25,
    input  logic        reset,
    input  logic        dn_download,
    input  logic [15:0] dn_addr,
    input  logic [7:0]  dn_data,
    input  logic        dn_wr,
    output logic        prog_we,
    output logic [12:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic        vec_we,
    output logic [9:0]  vec_addr,
    output logic [15:0] vec_data,
    output logic        prom_we,
    output logic [7:0]  prom_addr,
    output logic [7:0]  prom_data,
    output logic        rom_ready,
    output logic        rom_err,
    output logic [15:0] checksum
);

    state_e                r_state;
    logic                  r_dl_prev;
    logic [PROG_CNT_W-1:0] r_cnt_prog;
    logic [VEC_CNT_W-1:0]  r_cnt_vec;
    logic [PROM_CNT_W-1:0] r_cnt_prom;
    logic                  r_range_err;
    logic [15:0]           r_checksum;
    logic                  r_prog_we;
    logic [12:0]           r_prog_addr;
    logic [7:0]            r_prog_data;
    logic                  r_prom_we;
    logic [7:0]            r_prom_addr;
    logic [7:0]            r_prom_data;
    logic                  r_rom_ready;
    logic                  r_rom_err;

    logic        w_rise;
    logic        w_fall;
    logic        w_accept;
    region_e     w_region;
    logic        w_vec_wr;
    logic [10:0] w_vec_off;
    logic [7:0]  w_prom_off;
    logic        w_lo_valid;
    logic        w_order_err;
    logic        w_load_ok;

    assign w_rise     = dn_download & ~r_dl_prev;
    assign w_fall     = ~dn_download & r_dl_prev;
    assign w_accept   = dn_wr && (r_state == ST_LOAD);
    assign w_region   = decode_region(dn_addr);
    assign w_vec_wr   = w_accept && (w_region == REG_VEC);
    assign w_vec_off  = 11'(dn_addr - VEC_BASE);
    assign w_prom_off = 8'(dn_addr - PROM_BASE);
    assign w_load_ok  = (r_cnt_prog == PROG_CNT_FULL) && (r_cnt_vec == VEC_CNT_FULL) &&
                        (r_cnt_prom == PROM_CNT_FULL) && !w_lo_valid &&
                        !r_range_err && !w_order_err;

    llander_vec_packer u_vec_packer (
        .i_clk       (clk_25),
        .i_rst       (reset),
        .i_clear     (w_rise),
        .i_wr        (w_vec_wr),
        .i_off       (w_vec_off),
        .i_data      (dn_data),
        .o_we        (vec_we),
        .o_addr      (vec_addr),
        .o_data      (vec_data),
        .o_lo_valid  (w_lo_valid),
        .o_order_err (w_order_err)
    );

    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_dl_prev   <= 1'b0;
            r_cnt_prog  <= '0;
            r_cnt_vec   <= '0;
            r_cnt_prom  <= '0;
            r_range_err <= 1'b0;
            r_checksum  <= '0;
            r_prog_we   <= 1'b0;
            r_prog_addr <= '0;
            r_prog_data <= '0;
            r_prom_we   <= 1'b0;
            r_prom_addr <= '0;
            r_prom_data <= '0;
            r_rom_ready <= 1'b0;
            r_rom_err   <= 1'b0;
        end else begin
            r_dl_prev <= dn_download;
            r_prog_we <= 1'b0;
            r_prom_we <= 1'b0;
            if (w_rise) begin
                r_state     <= ST_LOAD;
                r_cnt_prog  <= '0;
                r_cnt_vec   <= '0;
                r_cnt_prom  <= '0;
                r_range_err <= 1'b0;
                r_checksum  <= '0;
                r_rom_ready <= 1'b0;
                r_rom_err   <= 1'b0;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        // A strobe on the same edge as the falling download is still taken.
                        if (w_accept) begin
                            if (w_region != REG_NONE)
                                r_checksum <= r_checksum + 16'(dn_data);
                            case (w_region)
                                REG_PROG: begin
                                    r_prog_we   <= 1'b1;
                                    r_prog_addr <= 13'(dn_addr);
                                    r_prog_data <= dn_data;
                                    if (!(&r_cnt_prog))
                                        r_cnt_prog <= r_cnt_prog + 1'b1;
                                end
                                REG_VEC: begin
                                    if (!(&r_cnt_vec))
                                        r_cnt_vec <= r_cnt_vec + 1'b1;
                                end
                                REG_PROM: begin
                                    r_prom_we   <= 1'b1;
                                    r_prom_addr <= w_prom_off;
                                    r_prom_data <= dn_data;
                                    if (!(&r_cnt_prom))
                                        r_cnt_prom <= r_cnt_prom + 1'b1;
                                end
                                default: r_range_err <= 1'b1;
                            endcase
                        end
                        if (w_fall)
                            r_state <= ST_CHECK;
                    end
                    ST_CHECK: begin
                        if (w_load_ok) begin
                            r_state     <= ST_READY;
                            r_rom_ready <= 1'b1;
                        end else begin
                            r_state   <= ST_ERR;
                            r_rom_err <= 1'b1;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign prog_we   = r_prog_we;
    assign prog_addr = r_prog_addr;
    assign prog_data = r_prog_data;
    assign prom_we   = r_prom_we;
    assign prom_addr = r_prom_addr;
    assign prom_data = r_prom_data;
    assign rom_ready = r_rom_ready;
    assign rom_err   = r_rom_err;
    assign checksum  = r_checksum;

endmodule

// File: tb/tb_llander_rom_loader.sv
// Randomized download scenarios for llander_rom_loader, checked against a
// byte-stream reference model of the ROM map, pairing rules and checksum.
module tb_llander_rom_loader;

    localparam int N_PROG  = 8192;
    localparam int N_VEC   = 2048;
    localparam int N_PROM  = 256;
    localparam int N_TOTAL = N_PROG + N_VEC + N_PROM;

    logic        clk_25 = 1'b0;
    logic        reset = 1'b1;
    logic        dn_download = 1'b0;
    logic [15:0] dn_addr = '0;
    logic [7:0]  dn_data = '0;
    logic        dn_wr = 1'b0;
    logic        prog_we;
    logic [12:0] prog_addr;
    logic [7:0]  prog_data;
    logic        vec_we;
    logic [9:0]  vec_addr;
    logic [15:0] vec_data;
    logic        prom_we;
    logic [7:0]  prom_addr;
    logic [7:0]  prom_data;
    logic        rom_ready;
    logic        rom_err;
    logic [15:0] checksum;

    int n_checks = 0;
    int n_fail   = 0;

    llander_rom_loader dut (
        .clk_25      (clk_25),
        .reset       (reset),
        .dn_download (dn_download),
        .dn_addr     (dn_addr),
        .dn_data     (dn_data),
        .dn_wr       (dn_wr),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .vec_we      (vec_we),
        .vec_addr    (vec_addr),
        .vec_data    (vec_data),
        .prom_we     (prom_we),
        .prom_addr   (prom_addr),
        .prom_data   (prom_data),
        .rom_ready   (rom_ready),
        .rom_err     (rom_err),
        .checksum    (checksum)
    );

    always #5 clk_25 = ~clk_25;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Stream under test and the expected ROM images it should produce.
    logic [15:0] q_addr[$];
    logic [7:0]  q_data[$];
    logic [7:0]  exp_prog[N_PROG];
    bit          exp_prog_ok[N_PROG];
    logic [15:0] exp_vec[N_VEC/2];
    bit          exp_vec_ok[N_VEC/2];
    logic [7:0]  exp_prom[N_PROM];
    bit          exp_prom_ok[N_PROM];
    int          exp_np, exp_nv, exp_npr;
    logic [15:0] exp_sum;

    // Monitor: counts write pulses and tallies any that disagree with the expected image.
    int          mon_np = 0, mon_nv = 0, mon_npr = 0, mon_bad = 0;
    logic [12:0] last_prog_addr = '0;
    logic [7:0]  last_prog_data = '0;
    logic [15:0] mon_vec0 = '0;
    int          b_np, b_nv, b_npr, b_bad;

    always @(negedge clk_25) begin
        if (prog_we) begin
            mon_np++;
            last_prog_addr = prog_addr;
            last_prog_data = prog_data;
            if (!(exp_prog_ok[prog_addr] && exp_prog[prog_addr] == prog_data))
                mon_bad++;
        end
        if (vec_we) begin
            mon_nv++;
            if (vec_addr == 10'd0)
                mon_vec0 = vec_data;
            if (!(exp_vec_ok[vec_addr] && exp_vec[vec_addr] == vec_data))
                mon_bad++;
        end
        if (prom_we) begin
            mon_npr++;
            if (!(exp_prom_ok[prom_addr] && exp_prom[prom_addr] == prom_data))
                mon_bad++;
        end
    end

    task automatic fill_ordered(input int n, input bit rand_data);
        q_addr.delete();
        q_data.delete();
        for (int i = 0; i < n; i++) begin
            q_addr.push_back(16'(i));
            q_data.push_back(rand_data ? 8'($urandom) : 8'(i));
        end
    endtask

    task automatic build_model();
        int  cp, cv, cpr, pidx, a, off;
        bit  err, pend;
        logic [7:0] pbyte, d;
        cp = 0; cv = 0; cpr = 0; pidx = 0; err = 0; pend = 0; pbyte = '0;
        exp_np = 0; exp_nv = 0; exp_npr = 0; exp_sum = '0;
        for (int i = 0; i < N_PROG; i++) exp_prog_ok[i] = 0;
        for (int i = 0; i < N_VEC/2; i++) exp_vec_ok[i] = 0;
        for (int i = 0; i < N_PROM; i++) exp_prom_ok[i] = 0;
        for (int i = 0; i < q_addr.size(); i++) begin
            a = int'(q_addr[i]);
            d = q_data[i];
            if (a < N_TOTAL)
                exp_sum = exp_sum + 16'(d);
            if (a < N_PROG) begin
                cp++; exp_np++;
                exp_prog[a] = d; exp_prog_ok[a] = 1;
            end else if (a < N_PROG + N_VEC) begin
                off = a - N_PROG;
                cv++;
                if (off % 2 == 0) begin
                    if (pend) err = 1;
                    pend = 1; pidx = off / 2; pbyte = d;
                end else if (pend && pidx == off / 2) begin
                    exp_nv++;
                    exp_vec[off/2] = {d, pbyte}; exp_vec_ok[off/2] = 1;
                    pend = 0;
                end else begin
                    err = 1;
                end
            end else if (a < N_TOTAL) begin
                cpr++; exp_npr++;
                exp_prom[a - N_PROG - N_VEC] = d; exp_prom_ok[a - N_PROG - N_VEC] = 1;
            end else begin
                err = 1;
            end
        end
        if (err || pend || cp != N_PROG || cv != N_VEC || cpr != N_PROM)
            $display("model: load %0d bytes expected to be rejected", q_addr.size());
    endtask

    task automatic tick();
        @(posedge clk_25);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [7:0] d, input bit fall);
        dn_addr = a;
        dn_data = d;
        dn_wr   = 1'b1;
        if (fall) dn_download = 1'b0;
        tick();
        dn_wr = 1'b0;
    endtask

    task automatic stream(input int from, input int upto, input bit fall_on_last);
        for (int i = from; i < upto; i++) begin
            if ($urandom_range(15) == 0) tick();
            send(q_addr[i], q_data[i], fall_on_last && (i == upto - 1));
        end
    endtask

    task automatic start_load(input string tag);
        build_model();
        b_np = mon_np; b_nv = mon_nv; b_npr = mon_npr; b_bad = mon_bad;
        dn_download = 1'b1;
        tick();
        check_val({tag, "_ready_clr"}, 32'(rom_ready), 32'd0);
        check_val({tag, "_err_clr"}, 32'(rom_err), 32'd0);
    endtask

    task automatic run_load(input string tag, input bit fall_on_last, input bit want_ready);
        start_load(tag);
        stream(0, q_addr.size(), fall_on_last);
        if (!fall_on_last) begin
            dn_download = 1'b0;
            tick();
        end
        check_val({tag, "_ready_in_check"}, 32'(rom_ready), 32'd0);
        tick();
        check_val({tag, "_ready"}, 32'(rom_ready), 32'(want_ready));
        check_val({tag, "_err"}, 32'(rom_err), 32'(!want_ready));
        check_val({tag, "_prog_cnt"}, 32'(mon_np - b_np), 32'(exp_np));
        check_val({tag, "_vec_cnt"}, 32'(mon_nv - b_nv), 32'(exp_nv));
        check_val({tag, "_prom_cnt"}, 32'(mon_npr - b_npr), 32'(exp_npr));
        check_val({tag, "_bad_writes"}, 32'(mon_bad - b_bad), 32'd0);
        check_val({tag, "_checksum"}, 32'(checksum), 32'(exp_sum));
        $display("load %s bytes=%0d ready=%0b err=%0b checksum=0x%04h", tag, q_addr.size(),
                 rom_ready, rom_err, checksum);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ctl"}, 32'({prog_we, vec_we, prom_we, rom_ready, rom_err}), 32'd0);
        check_val({tag, "_sum"}, 32'(checksum), 32'd0);
        check_val({tag, "_addr"}, 32'({prog_addr, vec_addr, prom_addr}), 32'd0);
        check_val({tag, "_data"}, {prog_data, prom_data, vec_data}, 32'd0);
    endtask

    logic [15:0] tmp_a;
    logic [7:0]  tmp_d;
    logic [15:0] saved_sum;

    initial begin
        repeat (3) tick();
        check_reset_outputs("por");
        reset = 1'b0;
        tick();

        // T1: full ordered load with data = addr[7:0]
        fill_ordered(N_TOTAL, 1'b0);
        run_load("full", 1'b0, 1'b1);
        check_val("full_last_prog_addr", 32'(last_prog_addr), 32'h1FFF);
        check_val("full_last_prog_data", 32'(last_prog_data), 32'hFF);
        check_val("full_vec_word0", 32'(mon_vec0), 32'h0100);

        // Strobes with the download inactive must be ignored.
        b_np = mon_np; b_nv = mon_nv; b_npr = mon_npr;
        saved_sum = checksum;
        for (int i = 0; i < 4; i++) send(16'(i * 2 + 16'h2000), 8'($urandom), 1'b0);
        tick();
        check_val("idle_wr_pulses", 32'((mon_np - b_np) + (mon_nv - b_nv) + (mon_npr - b_npr)), 32'd0);
        check_val("idle_wr_sum", 32'(checksum), 32'(saved_sum));
        check_val("idle_wr_ready", 32'(rom_ready), 32'd1);

        // T2: truncated load
        fill_ordered(10000, 1'b1);
        run_load("trunc", 1'b0, 1'b0);

        // T3: first vector pair sent odd-before-even
        fill_ordered(N_TOTAL, 1'b1);
        tmp_a = q_addr[16'h2000]; tmp_d = q_data[16'h2000];
        q_addr[16'h2000] = q_addr[16'h2001]; q_data[16'h2000] = q_data[16'h2001];
        q_addr[16'h2001] = tmp_a; q_data[16'h2001] = tmp_d;
        run_load("order", 1'b0, 1'b0);

        // T4: full load plus an out-of-range byte
        fill_ordered(N_TOTAL, 1'b1);
        q_addr.push_back(16'h3000);
        q_data.push_back(8'($urandom_range(255, 1)));
        run_load("range", 1'b0, 1'b0);

        // T5: reset part-way through, then a clean full load
        fill_ordered(N_TOTAL, 1'b1);
        start_load("abort");
        stream(0, 5000, 1'b0);
        reset = 1'b1;
        dn_download = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        tick();
        check_reset_outputs("midrst_hold");
        reset = 1'b0;
        tick();
        run_load("after_rst", 1'b0, 1'b1);

        // T6: second download from READY, last byte on the falling edge
        fill_ordered(N_TOTAL, 1'b1);
        run_load("second", 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
